// File: rtl/line_window_buf.sv
// line_window_buf
//
// Vertical line buffer for window filters. It stores the previous NUM_LINES-1
// video lines in a cascade of simple-dual-port RAMs. For every input pixel it
// presents one column of NUM_LINES taps: the current pixel plus the pixels at
// the same column in the lines above it. Output latency is one clock.
//
// Ports
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   in_vs       single-cycle frame-start pulse (clears row, column and ovf)
//   in_de       pixel valid; one contiguous high run is one line
//   in_data     pixel value
//   out_de      tap column valid (in_de delayed by one clock)
//   out_data    taps; tap k in bits [k*DATA_W +: DATA_W], k=0 current line,
//               k=i the line i rows above
//   out_win_ok  all taps hold real frame data (row >= NUM_LINES-1)
//   out_x       column index of the presented tap column
//   ovf         sticky: a line exceeded H_MAX pixels since the last in_vs
module line_window_buf #(
  parameter int DATA_W      = 8,
  parameter int H_MAX       = 1024,
  parameter int ADDR_W      = 10,
  parameter int NUM_LINES   = 3,
  parameter int BORDER_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_vs,
  input  logic                        in_de,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_de,
  output logic [NUM_LINES*DATA_W-1:0] out_data,
  output logic                        out_win_ok,
  output logic [ADDR_W-1:0]           out_x,
  output logic                        ovf
);

  localparam int              NR      = NUM_LINES - 1;  // number of line RAMs
  localparam logic [2:0]      ROW_MAX = 3'(NUM_LINES - 1);
  // One extra column bit so the counter can sit at H_MAX even when
  // H_MAX == 2**ADDR_W.
  localparam logic [ADDR_W:0] X_LIM   = (ADDR_W + 1)'(H_MAX);
  localparam logic [ADDR_W:0] X_ONE   = (ADDR_W + 1)'(1);

  logic [ADDR_W:0]   x;
  logic [ADDR_W:0]   x_eff;
  logic [2:0]        row;
  logic [2:0]        row_eff;
  logic              de_d;
  logic              aborted;
  logic              line_end;
  logic              ovf_pix;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] mem [NR][H_MAX];
  logic [DATA_W-1:0] rd_q [NR];
  logic [DATA_W-1:0] pix_q;
  logic [2:0]        row_q;
  logic              ovf_pix_q;
  logic [DATA_W-1:0] oldest;

  // in_vs takes effect on the pixel it arrives with, so the current pixel
  // uses cleared column/row values rather than the registered ones.
  // NOTE: every always_comb output gets a default assignment first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    x_eff    = in_vs ? '0 : x;
    row_eff  = in_vs ? '0 : row;
    ovf_pix  = in_de && (x_eff == X_LIM);
    line_end = de_d && !in_de;
    rd_addr  = x_eff[ADDR_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      row        <= '0;
      de_d       <= 1'b0;
      aborted    <= 1'b0;
      ovf        <= 1'b0;
      out_de     <= 1'b0;
      out_x      <= '0;
      out_win_ok <= 1'b0;
      pix_q      <= '0;
      row_q      <= '0;
      ovf_pix_q  <= 1'b0;
      for (int i = 0; i < NR; i++) rd_q[i] <= '0;
    end else begin
      de_d <= in_de;

      // Column counter: holds at H_MAX on overflow, restarts after a line.
      if (in_de)                  x <= ovf_pix ? x_eff : x_eff + X_ONE;
      else if (in_vs || line_end) x <= '0;

      // A line interrupted by in_vs is not counted when its run finally ends.
      if (in_vs)                                        row <= '0;
      else if (line_end && !aborted && row != ROW_MAX) row <= row + 3'd1;

      if (in_vs)         aborted <= de_d && in_de;
      else if (line_end) aborted <= 1'b0;

      if (in_vs)        ovf <= 1'b0;
      else if (ovf_pix) ovf <= 1'b1;

      out_de <= in_de;
      if (in_de) begin
        out_x      <= x_eff[ADDR_W-1:0];
        out_win_ok <= (row_eff == ROW_MAX);
        pix_q      <= in_data;
        row_q      <= row_eff;
        ovf_pix_q  <= ovf_pix;
        if (!ovf_pix) begin
          for (int i = 0; i < NR; i++) rd_q[i] <= mem[i][rd_addr];
        end
      end
    end
  end

  // Write-back one cycle after the read, at the same column. The read port
  // has already moved on to the next column, so both ports never hit the
  // same address in the same cycle. Each RAM takes the value just read from
  // the RAM one line newer, shifting the column down the cascade.
  // NOTE: the line RAMs have no reset; stale contents are masked by the row
  // counter, and a reset would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (out_de && !ovf_pix_q) begin
      mem[0][out_x] <= pix_q;
      for (int i = 1; i < NR; i++) mem[i][out_x] <= rd_q[i-1];
    end
  end

  // Tap assembly with top-border fill. Overflow pixels expose only tap 0.
  always_comb begin
    oldest = pix_q;
    for (int j = 1; j <= NR; j++) begin
      if (row_q == 3'(j)) oldest = rd_q[j-1];
    end

    out_data = '0;
    out_data[0 +: DATA_W] = pix_q;
    for (int k = 1; k <= NR; k++) begin
      if (ovf_pix_q)            out_data[k*DATA_W +: DATA_W] = '0;
      else if (3'(k) <= row_q)  out_data[k*DATA_W +: DATA_W] = rd_q[k-1];
      else if (BORDER_MODE == 1) out_data[k*DATA_W +: DATA_W] = oldest;
      else                       out_data[k*DATA_W +: DATA_W] = '0;
    end
  end

endmodule

// File: tb/tb_line_window_buf.sv
// Testbench for line_window_buf: two instances (zero fill and replicate fill,
// H_MAX=8) share one directed stimulus stream. A frame-level model pushes
// expected tap columns into per-instance queues; a negedge monitor pops and
// compares whenever out_de is high, and checks that out_data holds otherwise.
module tb_line_window_buf;

  localparam int DW = 8;
  localparam int HM = 8;
  localparam int AW = 3;
  localparam int NL = 3;

  typedef struct {
    int             due;
    logic [AW-1:0]  x;
    logic           x_care;
    logic [NL*DW-1:0] data;
    logic           win;
    logic           ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic in_vs;
  logic in_de;
  logic [DW-1:0] in_data;

  logic              de0, de1, win0, win1, ovf0, ovf1;
  logic [NL*DW-1:0]  data0, data1;
  logic [AW-1:0]     x0, x1;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [NL*DW-1:0] last0 = '0;
  logic [NL*DW-1:0] last1 = '0;

  // Reference model state: row index, column, sticky overflow and the two
  // previously stored lines per column.
  int   m_row = 0;
  int   m_x   = 0;
  bit   m_ovf = 0;
  bit   m_in_line = 0;
  bit   m_abort = 0;
  logic [DW-1:0] hist1 [HM];
  logic [DW-1:0] hist2 [HM];

  line_window_buf #(
    .DATA_W(DW), .H_MAX(HM), .ADDR_W(AW), .NUM_LINES(NL), .BORDER_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .out_de(de0), .out_data(data0), .out_win_ok(win0), .out_x(x0), .ovf(ovf0)
  );

  line_window_buf #(
    .DATA_W(DW), .H_MAX(HM), .ADDR_W(AW), .NUM_LINES(NL), .BORDER_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .out_de(de1), .out_data(data1), .out_win_ok(win1), .out_x(x1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic compare_out(input string tag, input exp_t e, input logic [NL*DW-1:0] data,
                             input logic [AW-1:0] x, input logic win, input logic ov);
    check({tag, " latency"}, 64'(cyc), 64'(e.due));
    check({tag, " data"}, 64'(data), 64'(e.data));
    check({tag, " win_ok"}, 64'(win), 64'(e.win));
    check({tag, " ovf"}, 64'(ov), 64'(e.ovf));
    if (e.x_care) check({tag, " out_x"}, 64'(x), 64'(e.x));
  endtask

  // Monitor: decoupled from stimulus, compares each presented column.
  always @(negedge clk) begin
    if (rst_n) begin
      if (de0) begin
        check("dut0 expected column", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) compare_out("dut0", q0.pop_front(), data0, x0, win0, ovf0);
      end else begin
        check("dut0 blank hold", 64'(data0), 64'(last0));
      end
      if (de1) begin
        check("dut1 expected column", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) compare_out("dut1", q1.pop_front(), data1, x1, win1, ovf1);
      end else begin
        check("dut1 blank hold", 64'(data1), 64'(last1));
      end
      last0 = data0;
      last1 = data1;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, " dut0 out_de"}, 64'(de0), 64'd0);
    check({tag, " dut0 out_data"}, 64'(data0), 64'd0);
    check({tag, " dut0 win_ok"}, 64'(win0), 64'd0);
    check({tag, " dut0 out_x"}, 64'(x0), 64'd0);
    check({tag, " dut0 ovf"}, 64'(ovf0), 64'd0);
    check({tag, " dut1 out_de"}, 64'(de1), 64'd0);
    check({tag, " dut1 out_data"}, 64'(data1), 64'd0);
    check({tag, " dut1 ovf"}, 64'(ovf1), 64'd0);
  endtask

  // Drive one pixel and push the expected tap column for both instances.
  task automatic drive_pix(input bit vs, input logic [DW-1:0] d);
    logic [DW-1:0] raw [NL];
    exp_t e0, e1;
    bit ovfp;
    int r;
    @(negedge clk);
    in_vs   = vs;
    in_de   = 1'b1;
    in_data = d;
    if (vs) begin
      m_abort = m_in_line;
      m_row   = 0;
      m_x     = 0;
      m_ovf   = 0;
    end
    ovfp   = (m_x == HM);
    r      = m_row;
    raw[0] = d;
    raw[1] = ovfp ? '0 : hist1[m_x];
    raw[2] = ovfp ? '0 : hist2[m_x];
    e0.data = '0;
    e1.data = '0;
    for (int k = 0; k < NL; k++) begin
      if (k == 0) begin
        e0.data[0 +: DW] = d;
        e1.data[0 +: DW] = d;
      end else if (ovfp) begin
        e0.data[k*DW +: DW] = '0;
        e1.data[k*DW +: DW] = '0;
      end else if (k <= r) begin
        e0.data[k*DW +: DW] = raw[k];
        e1.data[k*DW +: DW] = raw[k];
      end else begin
        e0.data[k*DW +: DW] = '0;
        e1.data[k*DW +: DW] = raw[r];
      end
    end
    e0.due    = cyc + 1;
    e0.x      = AW'(m_x);
    e0.x_care = !ovfp;
    e0.win    = (r == NL - 1);
    if (!ovfp) begin
      hist2[m_x] = hist1[m_x];
      hist1[m_x] = d;
      m_x++;
    end
    m_ovf     = m_ovf | ovfp;
    m_in_line = 1;
    e0.ovf    = m_ovf;
    e1.due    = e0.due;
    e1.x      = e0.x;
    e1.x_care = e0.x_care;
    e1.win    = e0.win;
    e1.ovf    = e0.ovf;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic end_line(input int gap);
    @(negedge clk);
    in_vs = 1'b0;
    in_de = 1'b0;
    if (m_in_line && !m_abort && m_row < NL - 1) m_row++;
    m_x       = 0;
    m_in_line = 0;
    m_abort   = 0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_line(input int n, input logic [DW-1:0] base, input bit vs_first);
    for (int c = 0; c < n; c++) drive_pix(vs_first && c == 0, base + DW'(c));
    end_line(2);
  endtask

  // Frame-start pulse during blanking; ovf must clear on the following edge.
  task automatic vs_blank();
    @(negedge clk);
    in_vs = 1'b1;
    in_de = 1'b0;
    m_row = 0;
    m_x   = 0;
    m_ovf = 0;
    @(negedge clk);
    in_vs = 1'b0;
    check("ovf cleared by in_vs dut0", 64'(ovf0), 64'd0);
    check("ovf cleared by in_vs dut1", 64'(ovf1), 64'd0);
  endtask

  // Reset pulse arriving mid-line, between clock edges.
  task automatic reset_mid();
    @(negedge clk);
    in_de   = 1'b1;
    in_data = 8'hFF;
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async reset");
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    @(negedge clk);
    in_de     = 1'b0;
    rst_n     = 1'b1;
    m_row     = 0;
    m_x       = 0;
    m_ovf     = 0;
    m_in_line = 0;
    m_abort   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < HM; i++) begin
      hist1[i] = '0;
      hist2[i] = '0;
    end
    rst_n   = 1'b0;
    in_vs   = 1'b0;
    in_de   = 1'b0;
    in_data = '0;
    #3 check_zero_outputs("power-on reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Frame A: 16*row+col, frame start coincident with the first pixel.
    for (int r = 0; r < 4; r++) send_line(8, DW'(16 * r), r == 0);
    // Overlong line: pixels 9 and 10 overflow.
    send_line(10, 8'h40, 0);
    vs_blank();

    // Frame B: in_vs in the middle of row 2 aborts that line.
    send_line(8, 8'h80, 0);
    send_line(8, 8'h90, 0);
    for (int c = 0; c < 4; c++) drive_pix(0, 8'hA0 + DW'(c));
    for (int c = 0; c < 4; c++) drive_pix(c == 0, 8'hB0 + DW'(c));
    end_line(2);
    send_line(8, 8'hC0, 0);
    send_line(8, 8'hD0, 0);
    send_line(8, 8'hE0, 0);
    // New frame starting on a pixel while the row counter is saturated.
    send_line(8, 8'h60, 1);

    // Set ovf, start a line and reset in the middle of it.
    send_line(9, 8'h20, 0);
    for (int c = 0; c < 3; c++) drive_pix(0, 8'hF0 + DW'(c));
    reset_mid();
    send_line(8, 8'h30, 0);
    send_line(8, 8'h40, 0);
    send_line(8, 8'h50, 0);

    repeat (3) @(negedge clk);
    check("dut0 queue drained", 64'(q0.size()), 64'd0);
    check("dut1 queue drained", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
